mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide responder for the pipelined MIPS core; serves E-stage mult/div/mthi/mtlo requests.
//  The core raises start with op and operands; the unit answers with busy; results land in internal HI/LO.
//  The core's hazard unit stalls any mult/div/mfhi/mflo/mthi/mtlo in E while busy=1 or start=1.

---
 rtl/mul_div_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle multiply/divide responder for the pipelined MIPS core.
//   It accepts a request from the E stage, holds busy for a fixed number of
//   cycles, and then commits the result into HI/LO. MTHI and MTLO write
//   HI or LO directly at the accepting edge and do not raise busy.
//
//   The result is computed in the same cycle the request is accepted and is
//   held in pending registers. The busy window models the latency that the
//   core's hazard unit expects.
//
// Parameters
//   MULT_CYCLES  busy length for MULT/MULTU (and MADD*/MSUB*), 1..15
//   DIV_CYCLES   busy length for DIV/DIVU, 1..15
//
// Optional feature
//   MDU_MADD_EN  when defined, ops 6..9 (MADD/MADDU/MSUB/MSUBU) accumulate
//                into {HI,LO}. When it is not defined, these ops are ignored
//                like any unknown op, and no accumulate adder is built.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous reset, active low
//   start  in   request strobe, qualified by op
//   op     in   4-bit opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI,
//               5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU)
//   A      in   rs operand
//   B      in   rt operand
//   busy   out  high while a multi-cycle op is in flight
//   HI     out  HI register
//   LO     out  LO register
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    hilo_t       pend;
    hilo_t       res;
    logic        load, commit, wr_hi, wr_lo;
    logic        is_mul, is_div, sgn;

    // ---------------- opcode decode ----------------
    // Even opcodes in the arithmetic groups are the signed variants.
    assign sgn = ~op[0];

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        is_div = (op == OP_DIV) || (op == OP_DIVU);
    end

    // ---------------- multiplier ----------------
    logic [63:0] prod_s, prod_u, prod, mul_res;

    assign prod_s = 64'($signed(A)) * 64'($signed(B));
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod   = sgn ? prod_s : prod_u;

`ifdef MDU_MADD_EN
    // Accumulate against HI/LO as they stand at acceptance. HI/LO cannot
    // change again until this op commits, so this is also the value at
    // completion.
    always_comb begin
        mul_res = prod;
        if ((op == OP_MADD) || (op == OP_MADDU))
            mul_res = {HI, LO} + prod;
        else if ((op == OP_MSUB) || (op == OP_MSUBU))
            mul_res = {HI, LO} - prod;
    end
`else
    assign mul_res = prod;
`endif

    // ---------------- divider ----------------
    // Signed division runs on magnitudes, and the signs are restored
    // afterwards. This makes 0x80000000 / -1 wrap to 0x80000000 with a
    // zero remainder, without any special case.
    logic [31:0] ua, ub, uq, ur, dq, dr;

    always_comb begin
        ua = (sgn && A[31]) ? -A : A;
        ub = (sgn && B[31]) ? -B : B;
        uq = 32'd0;
        ur = 32'd0;
        if (ub != 32'd0) begin
            uq = ua / ub;
            ur = ua % ub;
        end
        dq = (sgn && (A[31] ^ B[31])) ? -uq : uq;
        dr = (sgn && A[31]) ? -ur : ur;
    end

    // Divide by zero still runs the full busy window, but it commits the
    // current HI/LO, so the registers are left unchanged.
    always_comb begin
        res = mul_res;
        if (is_div) begin
            if (B == 32'd0) begin
                res.hi = HI;
                res.lo = LO;
            end else begin
                res.hi = dr;
                res.lo = dq;
            end
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        commit    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        load      = 1'b1;
                        cnt_nxt   = 4'(MULT_CYCLES);
                        state_nxt = RUN;
                    end else if (is_div) begin
                        load      = 1'b1;
                        cnt_nxt   = 4'(DIV_CYCLES);
                        state_nxt = RUN;
                    end else if (op == OP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (op == OP_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            RUN: begin
                // A start that arrives while busy is ignored here.
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            pend  <= '0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load)
                pend <= res;
            if (commit) begin
                HI <= pend.hi;
                LO <= pend.lo;
            end
            if (wr_hi)
                HI <= A;
            if (wr_lo)
                LO <= A;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Drives directed scenarios and then randomized requests into
//   mul_div_unit. The expected values come from a reference model that uses
//   64-bit integer arithmetic on the architectural HI/LO.
//
//   Inputs are driven on the falling edge, and outputs are sampled on the
//   falling edge. Define MDU_MADD_EN for both the DUT and the bench to
//   exercise the accumulate ops.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int nvec = 0;
    int nerr = 0;
    int viol = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    // Counts requests that arrive while the unit is busy, which the core's
    // protocol forbids.
    always @(posedge clk)
        if (reset && start && busy)
            viol <= viol + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo and returns the expected busy length.
    function automatic int model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa  = longint'($signed(a));
        longint      sb  = longint'($signed(b));
        logic [63:0] ua  = {32'd0, a};
        logic [63:0] ub  = {32'd0, b};
        logic [63:0] acc = {m_hi, m_lo};
        logic [63:0] r;
        longint      q, rm;
        case (o)
            4'd0: begin r = sa * sb; {m_hi, m_lo} = r; return MC; end
            4'd1: begin r = ua * ub; {m_hi, m_lo} = r; return MC; end
            4'd2: begin
                if (b != 0) begin
                    q = sa / sb; rm = sa % sb;
                    m_lo = q[31:0]; m_hi = rm[31:0];
                end
                return DC;
            end
            4'd3: begin
                if (b != 0) begin
                    r = ua / ub; m_lo = r[31:0];
                    r = ua % ub; m_hi = r[31:0];
                end
                return DC;
            end
            4'd4: begin m_hi = a; return 0; end
            4'd5: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
            4'd6: begin r = acc + sa * sb; {m_hi, m_lo} = r; return MC; end
            4'd7: begin r = acc + ua * ub; {m_hi, m_lo} = r; return MC; end
            4'd8: begin r = acc - sa * sb; {m_hi, m_lo} = r; return MC; end
            4'd9: begin r = acc - ua * ub; {m_hi, m_lo} = r; return MC; end
`endif
            default: return 0;
        endcase
    endfunction

    // Issues one request, checks that HI/LO hold during busy, checks the busy
    // length, and checks the committed HI/LO.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] old_hi = m_hi;
        logic [31:0] old_lo = m_lo;
        int exp_n, n;
        exp_n = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 4'hF;
        n = 0;
        while (busy && n < 40) begin
            if (HI !== old_hi || LO !== old_lo) begin
                chk("hold_hi", {32'd0, HI}, {32'd0, old_hi});
                chk("hold_lo", {32'd0, LO}, {32'd0, old_lo});
            end
            n++;
            @(negedge clk);
        end
        chk($sformatf("busy_len op%0d", o), 64'(n), 64'(exp_n));
        chk($sformatf("hi op%0d", o), {32'd0, HI}, {32'd0, m_hi});
        chk($sformatf("lo op%0d", o), {32'd0, LO}, {32'd0, m_lo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = 4'hF; A = '0; B = '0;

        // Reset
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", {32'd0, HI}, 64'd0);
        chk("rst_lo", {32'd0, LO}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // Directed arithmetic cases
        do_op(4'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_const", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo_const", {32'd0, LO}, 64'h0000_0000_FFFF_FFFA);
        do_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi_const", {32'd0, HI}, 64'h2);
        do_op(4'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_const", {32'd0, LO}, 64'h0000_0000_FFFF_FFFD);
        chk("div_hi_const", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        do_op(4'd3, 32'd7, 32'd2);
        chk("divu_lo_const", {32'd0, LO}, 64'd3);
        chk("divu_hi_const", {32'd0, HI}, 64'd1);
        do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", {32'd0, LO}, 64'h8000_0000);
        chk("div_ovf_hi", {32'd0, HI}, 64'd0);

        // MTHI takes effect at the accepting edge, without busy
        do_op(4'd4, 32'h1234_5678, 32'd0);
        chk("mthi_const", {32'd0, HI}, 64'h1234_5678);

        // Divide by zero leaves HI/LO unchanged
        do_op(4'd4, 32'd5, 32'd0);
        do_op(4'd5, 32'd6, 32'd0);
        do_op(4'd2, 32'd7, 32'd0);
        chk("dbz_hi", {32'd0, HI}, 64'd5);
        chk("dbz_lo", {32'd0, LO}, 64'd6);

        // An MTLO issued while busy is ignored
        void'(model(4'd0, 32'd3, 32'd4));
        @(negedge clk);
        start = 1'b1; op = 4'd0; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 4'd5; A = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; op = 4'hF;
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        chk("viol_busy_len", 64'(n + 2), 64'(MC));
        chk("viol_lo", {32'd0, LO}, 64'd12);
        chk("viol_hi", {32'd0, HI}, 64'd0);
        chk("viol_seen", 64'(viol), 64'd1);

        // MADDU, or an ignored op when the accumulate feature is absent
        do_op(4'd4, 32'd0, 32'd0);
        do_op(4'd5, 32'hFFFF_FFFF, 32'd0);
        do_op(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("maddu_hi", {32'd0, HI}, 64'd1);
        chk("maddu_lo", {32'd0, LO}, 64'd0);
`else
        chk("maddu_off_hi", {32'd0, HI}, 64'd0);
        chk("maddu_off_lo", {32'd0, LO}, 64'hFFFF_FFFF);
`endif

        // Randomized requests
        for (int i = 0; i < 150; i++)
            do_op(4'($urandom_range(0, 15)), pick(), pick());

        // Reset in the third busy cycle abandons the op in flight
        do_op(4'd4, 32'hAAAA_5555, 32'd0);
        @(negedge clk);
        start = 1'b1; op = 4'd0; A = 32'd5; B = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_hi", {32'd0, HI}, 64'd0);
        chk("mid_rst_lo", {32'd0, LO}, 64'd0);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_hi", {32'd0, HI}, 64'd0);
        chk("post_rst_lo", {32'd0, LO}, 64'd0);
        do_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
